universal_shift_reg: RTL and testbench

Parametrised universal shift register with a command handshake and a multi-step sequencer. One accepted command can load, clear, shift left or right, or rotate by a programmable number of positions, at one position per clock. It keeps the gate-level shift register's true and complement outputs and its serial inputs, generalised to WIDTH bits. It sits between a command source (controller, or a bench driver) and serial/parallel datapath consumers.

---
 rtl/universal_shift_pkg.sv | 41 ++++
 rtl/shift_step.sv | 37 +++
 rtl/universal_shift_reg.sv | 139 +++++++++++++
 tb/tb_universal_shift_reg.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/universal_shift_pkg.sv
// rtl/universal_shift_pkg.sv - opcodes, state encoding and decode helper for universal_shift_reg
//
// Purpose : Shared definitions for the universal shift register slice.
// Contents: OP_* opcode localparams, state_t (ST_IDLE / ST_RUN),
//           is_step_op() which tells whether an opcode walks the sequencer.
// Config  : ROTATE_EN - when defined, ROL/ROR count as multi-step operations.

package universal_shift_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_SHR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_CLR  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // True for opcodes that advance one position per clock in RUN.
  // Without rotate support, ROL/ROR fall through to the single-edge NOP path.
  function automatic logic is_step_op(input logic [2:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_SHL,
      OP_SHR: r = 1'b1;
`ifdef ROTATE_EN
      OP_ROL,
      OP_ROR: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational single-position shift/rotate step
//
// Purpose : Produces the register value after one step of the given opcode.
//           Opcodes that are not shift/rotate pass the value through.
// Ports   : i_q      [WIDTH] current register value
//           i_op     [3]     latched opcode
//           i_sin_l  [1]     serial in, enters bit 0 on SHL
//           i_sin_r  [1]     serial in, enters bit WIDTH-1 on SHR
//           o_q_next [WIDTH] value after one step
// Config  : ROTATE_EN - when undefined, no rotate muxing is built.

module shift_step
  import universal_shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic [2:0]       i_op,
  input  logic             i_sin_l,
  input  logic             i_sin_r,
  output logic [WIDTH-1:0] o_q_next
);

  always_comb begin
    o_q_next = i_q;
    case (i_op)
      OP_SHL:  o_q_next = {i_q[WIDTH-2:0], i_sin_l};
      OP_SHR:  o_q_next = {i_sin_r, i_q[WIDTH-1:1]};
`ifdef ROTATE_EN
      OP_ROL:  o_q_next = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
      OP_ROR:  o_q_next = {i_q[0], i_q[WIDTH-1:1]};
`endif
      default: o_q_next = i_q;
    endcase
  end

endmodule

// File: rtl/universal_shift_reg.sv
// rtl/universal_shift_reg.sv - universal shift register with command handshake and step sequencer
//
// Purpose : Accepts one command at a time; LOAD/CLR/NOP/amount-0 complete at
//           the acceptance edge, shift/rotate by N walk N edges in RUN.
// Ports   : clk, rst          clock, synchronous active-high reset
//           cmd_valid/ready   command handshake (ready only in IDLE)
//           cmd_op  [3]       opcode (see universal_shift_pkg)
//           cmd_amt [CNT_W]   step count for shift/rotate
//           load_data [WIDTH] parallel load value
//           sin_l, sin_r      serial inputs, sampled on every step edge
//           q, qbar [WIDTH]   register contents and complement
//           sout_l, sout_r    q msb / q lsb
//           busy              high in RUN
//           done              one-cycle completion pulse
// Config  : ROTATE_EN - enables ROL/ROR; otherwise they execute as NOP.

module universal_shift_reg
  import universal_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_amt,
  input  logic [WIDTH-1:0] load_data,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  state_t             r_state;
  state_t             w_state_next;
  logic [2:0]         r_op;
  logic [2:0]         w_op_next;
  logic [CNT_W-1:0]   r_rem;
  logic [CNT_W-1:0]   w_rem_next;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   w_q_next;
  logic               r_done;
  logic               w_done_next;
  logic [WIDTH-1:0]   w_step;
  logic               w_accept;
  logic               w_last_step;

  // The step datapath always looks at the latched opcode; it is only
  // consumed while in RUN, where r_op holds the shift/rotate being executed.
  shift_step #(
    .WIDTH (WIDTH)
  ) u_shift_step (
    .i_q      (r_q),
    .i_op     (r_op),
    .i_sin_l  (sin_l),
    .i_sin_r  (sin_r),
    .o_q_next (w_step)
  );

  assign w_accept    = cmd_valid && (r_state == ST_IDLE);
  // Treat a zero count in RUN as the last step too, so a corrupted counter
  // can never leave the sequencer spinning.
  assign w_last_step = (r_rem == CNT_W'(1)) || (r_rem == '0);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_op    <= OP_NOP;
      r_rem   <= '0;
      r_q     <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_op    <= w_op_next;
      r_rem   <= w_rem_next;
      r_q     <= w_q_next;
      r_done  <= w_done_next;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    w_state_next = r_state;
    w_op_next    = r_op;
    w_rem_next   = r_rem;
    w_q_next     = r_q;
    w_done_next  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_op_next  = cmd_op;
          w_rem_next = cmd_amt;
          if (is_step_op(cmd_op) && (cmd_amt != '0)) begin
            w_state_next = ST_RUN;
          end else begin
            // Single-edge commands: LOAD, CLR, NOP, reserved, amount 0,
            // and rotates when rotate support is compiled out.
            w_done_next = 1'b1;
            if (cmd_op == OP_LOAD) begin
              w_q_next = load_data;
            end else if (cmd_op == OP_CLR) begin
              w_q_next = '0;
            end
          end
        end
      end
      ST_RUN: begin
        w_q_next   = w_step;
        w_rem_next = r_rem - CNT_W'(1);
        if (w_last_step) begin
          w_state_next = ST_IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    cmd_ready = (r_state == ST_IDLE);
    busy      = (r_state == ST_RUN);
    done      = r_done;
    q         = r_q;
    qbar      = ~r_q;
    sout_l    = r_q[WIDTH-1];
    sout_r    = r_q[0];
  end

endmodule

// File: tb/tb_universal_shift_reg.sv
// tb/tb_universal_shift_reg.sv - self-checking bench for universal_shift_reg

module tb_universal_shift_reg;

  logic       clk;
  logic       rst;

  // WIDTH=8 instance
  logic       c8_valid;
  logic       c8_ready;
  logic [2:0] c8_op;
  logic [3:0] c8_amt;
  logic [7:0] c8_data;
  logic       c8_sl;
  logic       c8_sr;
  logic [7:0] c8_q;
  logic [7:0] c8_qbar;
  logic       c8_soutl;
  logic       c8_soutr;
  logic       c8_busy;
  logic       c8_done;

  // WIDTH=4 instance
  logic       c4_valid;
  logic       c4_ready;
  logic [2:0] c4_op;
  logic [2:0] c4_amt;
  logic [3:0] c4_data;
  logic       c4_sl;
  logic       c4_sr;
  logic [3:0] c4_q;
  logic [3:0] c4_qbar;
  logic       c4_soutl;
  logic       c4_soutr;
  logic       c4_busy;
  logic       c4_done;

  int checks;
  int failures;

  universal_shift_reg #(.WIDTH(8)) u8 (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (c8_valid),
    .cmd_ready (c8_ready),
    .cmd_op    (c8_op),
    .cmd_amt   (c8_amt),
    .load_data (c8_data),
    .sin_l     (c8_sl),
    .sin_r     (c8_sr),
    .q         (c8_q),
    .qbar      (c8_qbar),
    .sout_l    (c8_soutl),
    .sout_r    (c8_soutr),
    .busy      (c8_busy),
    .done      (c8_done)
  );

  universal_shift_reg #(.WIDTH(4)) u4 (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (c4_valid),
    .cmd_ready (c4_ready),
    .cmd_op    (c4_op),
    .cmd_amt   (c4_amt),
    .load_data (c4_data),
    .sin_l     (c4_sl),
    .sin_r     (c4_sr),
    .q         (c4_q),
    .qbar      (c4_qbar),
    .sout_l    (c4_soutl),
    .sout_r    (c4_soutr),
    .busy      (c4_busy),
    .done      (c4_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [3:0] amt;
    logic [7:0] data;
    logic       sl;
    logic       sr;
    logic [7:0] exp_q;
    int         exp_n;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [2:0] op, input logic [3:0] amt,
                              input logic [7:0] data, input logic sl, input logic sr,
                              input logic [7:0] exp_q, input int exp_n);
    vec_t v;
    v.name = name; v.op = op; v.amt = amt; v.data = data;
    v.sl = sl; v.sr = sr; v.exp_q = exp_q; v.exp_n = exp_n;
    return v;
  endfunction

  // Issue one command on the 8-bit instance, count busy cycles until done,
  // then check the final value, outputs and the one-cycle done pulse.
  task automatic run8(input vec_t v);
    int n;
    @(negedge clk);
    chk({v.name, "_ready"}, {31'd0, c8_ready}, 32'd1);
    c8_op = v.op; c8_amt = v.amt; c8_data = v.data; c8_sl = v.sl; c8_sr = v.sr;
    c8_valid = 1'b1;
    @(posedge clk); #1;
    c8_valid = 1'b0;
    n = 0;
    while (!c8_done && n < 40) begin
      chk({v.name, "_busy"}, {31'd0, c8_busy}, 32'd1);
      @(posedge clk); #1;
      n++;
    end
    chk({v.name, "_steps"}, n, v.exp_n);
    chk({v.name, "_done"}, {31'd0, c8_done}, 32'd1);
    chk({v.name, "_q"}, {24'd0, c8_q}, {24'd0, v.exp_q});
    chk({v.name, "_qbar"}, {24'd0, c8_qbar}, {24'd0, ~v.exp_q});
    chk({v.name, "_sout"}, {30'd0, c8_soutl, c8_soutr}, {30'd0, v.exp_q[7], v.exp_q[0]});
    chk({v.name, "_idle"}, {30'd0, c8_busy, c8_ready}, 32'd1);
    @(posedge clk); #1;
    chk({v.name, "_done_drop"}, {31'd0, c8_done}, 32'd0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    c8_valid = 1'b0; c8_op = 3'd0; c8_amt = 4'd0; c8_data = 8'd0; c8_sl = 1'b0; c8_sr = 1'b0;
    c4_valid = 1'b0; c4_op = 3'd0; c4_amt = 3'd0; c4_data = 4'd0; c4_sl = 1'b0; c4_sr = 1'b0;

    vecs[0]  = mk("shr2",   3'b011, 4'd2,  8'h00, 1'b0, 1'b0, 8'h0B, 2);
    vecs[1]  = mk("shl0",   3'b010, 4'd0,  8'h00, 1'b1, 1'b0, 8'h0B, 0);
    vecs[2]  = mk("ld81",   3'b001, 4'd0,  8'h81, 1'b0, 1'b0, 8'h81, 0);
`ifdef ROTATE_EN
    vecs[3]  = mk("rol8",   3'b100, 4'd8,  8'h00, 1'b0, 1'b0, 8'h81, 8);
    vecs[4]  = mk("ror1",   3'b101, 4'd1,  8'h00, 1'b0, 1'b0, 8'hC0, 1);
`else
    vecs[3]  = mk("rol8",   3'b100, 4'd8,  8'h00, 1'b0, 1'b0, 8'h81, 0);
    vecs[4]  = mk("ror1",   3'b101, 4'd1,  8'h00, 1'b0, 1'b0, 8'h81, 0);
`endif
    vecs[5]  = mk("clr",    3'b110, 4'd3,  8'hFF, 1'b1, 1'b1, 8'h00, 0);
    vecs[6]  = mk("nop",    3'b000, 4'd3,  8'hFF, 1'b1, 1'b1, 8'h00, 0);
    vecs[7]  = mk("rsvd",   3'b111, 4'd3,  8'hFF, 1'b1, 1'b1, 8'h00, 0);
    vecs[8]  = mk("shr10",  3'b011, 4'd10, 8'h00, 1'b0, 1'b1, 8'hFF, 10);
    vecs[9]  = mk("shl8",   3'b010, 4'd8,  8'h00, 1'b0, 1'b1, 8'h00, 8);
    vecs[10] = mk("ld3c",   3'b001, 4'd0,  8'h3C, 1'b0, 1'b0, 8'h3C, 0);
`ifdef ROTATE_EN
    vecs[11] = mk("rol3",   3'b100, 4'd3,  8'h00, 1'b0, 1'b0, 8'hE1, 3);
    vecs[12] = mk("ror4",   3'b101, 4'd4,  8'h00, 1'b0, 1'b0, 8'h1E, 4);
`else
    vecs[11] = mk("rol3",   3'b100, 4'd3,  8'h00, 1'b0, 1'b0, 8'h3C, 0);
    vecs[12] = mk("ror4",   3'b101, 4'd4,  8'h00, 1'b0, 1'b0, 8'h3C, 0);
`endif

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", {24'd0, c8_q}, 32'h00);
    chk("rst_qbar", {24'd0, c8_qbar}, 32'hFF);
    chk("rst_ready", {31'd0, c8_ready}, 32'd1);
    chk("rst_busy", {31'd0, c8_busy}, 32'd0);
    chk("rst_done", {31'd0, c8_done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // LOAD A5, then SHL 3 stepped by hand with cmd_valid held mid-run.
    run8(mk("lda5", 3'b001, 4'd0, 8'hA5, 1'b0, 1'b0, 8'hA5, 0));
    @(negedge clk);
    c8_op = 3'b010; c8_amt = 4'd3; c8_sl = 1'b1; c8_valid = 1'b1;
    @(posedge clk); #1;
    chk("shl3_e0_q", {24'd0, c8_q}, 32'hA5);
    chk("shl3_e0_busy", {30'd0, c8_busy, c8_ready}, 32'd2);
    c8_op = 3'b001; c8_data = 8'h00;   // ignored while busy
    @(posedge clk); #1;
    chk("shl3_e1_q", {24'd0, c8_q}, 32'h4B);
    chk("shl3_e1_busy", {31'd0, c8_busy}, 32'd1);
    @(posedge clk); #1;
    chk("shl3_e2_q", {24'd0, c8_q}, 32'h97);
    chk("shl3_e2_done", {31'd0, c8_done}, 32'd0);
    c8_valid = 1'b0;
    @(posedge clk); #1;
    chk("shl3_e3_q", {24'd0, c8_q}, 32'h2F);
    chk("shl3_e3_done", {31'd0, c8_done}, 32'd1);
    chk("shl3_e3_ready", {30'd0, c8_busy, c8_ready}, 32'd1);
    @(posedge clk); #1;
    chk("shl3_done_drop", {31'd0, c8_done}, 32'd0);

    // Table of single commands starting from q=2F.
    for (int i = 0; i < 13; i++) begin
      run8(vecs[i]);
    end

    // Reset mid-command: SHR 5 from FF, reset after the 2nd step.
    run8(mk("ldff", 3'b001, 4'd0, 8'hFF, 1'b0, 1'b0, 8'hFF, 0));
    @(negedge clk);
    c8_op = 3'b011; c8_amt = 4'd5; c8_sr = 1'b0; c8_valid = 1'b1;
    @(posedge clk); #1;
    c8_valid = 1'b0;
    @(posedge clk); #1;
    chk("rsm_e1_q", {24'd0, c8_q}, 32'h7F);
    @(posedge clk); #1;
    chk("rsm_e2_q", {24'd0, c8_q}, 32'h3F);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rsm_q", {24'd0, c8_q}, 32'h00);
    chk("rsm_qbar", {24'd0, c8_qbar}, 32'hFF);
    chk("rsm_flags", {29'd0, c8_busy, c8_done, c8_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rsm_no_done", {31'd0, c8_done}, 32'd0);
    chk("rsm_q_hold", {24'd0, c8_q}, 32'h00);
    run8(mk("rsm_ld3c", 3'b001, 4'd0, 8'h3C, 1'b0, 1'b0, 8'h3C, 0));

    // WIDTH=4: LOAD 9, then SHL 1 accepted in the done cycle.
    @(negedge clk);
    c4_op = 3'b001; c4_data = 4'h9; c4_valid = 1'b1;
    @(posedge clk); #1;
    chk("w4_ld_q", {28'd0, c4_q}, 32'h9);
    chk("w4_ld_qbar", {28'd0, c4_qbar}, 32'h6);
    chk("w4_ld_done", {30'd0, c4_done, c4_ready}, 32'd3);
    c4_op = 3'b010; c4_amt = 3'd1; c4_sl = 1'b0;
    @(posedge clk); #1;
    c4_valid = 1'b0;
    chk("w4_shl_e0", {29'd0, c4_busy, c4_done, c4_ready}, 32'd4);
    chk("w4_shl_e0_q", {28'd0, c4_q}, 32'h9);
    @(posedge clk); #1;
    chk("w4_shl_q", {28'd0, c4_q}, 32'h2);
    chk("w4_shl_done", {29'd0, c4_busy, c4_done, c4_ready}, 32'd3);
    chk("w4_sout", {30'd0, c4_soutl, c4_soutr}, 32'd0);
    @(posedge clk); #1;
    chk("w4_done_drop", {31'd0, c4_done}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
